fmap_streamer: RTL and testbench
================================

FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 Parameter DATA_W, default 32, width of the signed feature-map word.
REQ-002 Parameter DEPTH, default 576, frame-buffer entries (24x24 frame).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 state  input  1  frame size select: 0 = 24x24 (576 words), 1 = 8x8 (64 words); sampled only on an accepted start.
REQ-006 wr_en  input  1  frame-buffer write strobe.
REQ-007 wr_addr  input  10  frame-buffer write address.
REQ-008 wr_data  input  DATA_W  signed write data.
REQ-009 start  input  1  single-cycle request to stream one frame.
REQ-010 ovalid  output  1  dout valid; drives the pooling stage's ivalid.
REQ-011 dout  output  DATA_W  signed pixel, raster order; drives the pooling stage's din.
REQ-012 busy  output  1  high while a frame is being streamed.
REQ-013 done  output  1  one-cycle pulse after the last word of a frame.

Function
REQ-014 FSM states: IDLE, PREFETCH, STREAM, FINISH.
- IDLE: waits for start.
- PREFETCH: one cycle.
- STREAM: words are emitted.
- FINISH: one cycle, done = 1, then returns to IDLE.
REQ-015 Accepted start (start = 1 in IDLE) latches state into an internal frame size (576 or 64), clears the read counter and enters PREFETCH.
- busy rises the cycle after acceptance.
REQ-016 Read latency:
- Start sampled at edge N -> PREFETCH issues a read of address 0.
- First word appears with ovalid = 1 after edge N+2.
REQ-017 In STREAM, ovalid = 1 on every cycle, with no gaps, for exactly frame-size cycles.
- dout = buffer[k] on the k-th valid cycle, k = 0 .. size-1.
- The downstream stage has no backpressure.
REQ-018 The read counter increments once per emitted word.
- After word size-1 the FSM enters FINISH.
- ovalid = 0 and dout holds its last value from that cycle on.
REQ-019 In FINISH: done = 1 and busy = 0 for one cycle, then IDLE.
REQ-020 start is ignored in PREFETCH, STREAM and FINISH; no queuing.
REQ-021 A change on state while busy has no effect; only the latched size governs the frame length.
REQ-022 Writes (wr_en = 1) are accepted only in IDLE and FINISH; they are silently dropped in PREFETCH and STREAM.
REQ-023 wr_addr >= DEPTH is ignored; no wrap and no aliasing.
REQ-024 When write and start coincide in IDLE, the write completes first: a write to address 0 is visible as the first streamed word.
REQ-025 The frame buffer is a single-port-write, single-port-read synchronous RAM of DEPTH x DATA_W with a registered read.
REQ-026 dout passes data through with no arithmetic; sign is preserved.

Reset
REQ-027 With rstn = 0, asynchronously:
- ovalid = 0, dout = 0, busy = 0, done = 0.
- FSM = IDLE, read counter = 0, latched size = 576.
REQ-028 Buffer contents are not reset and survive reset.
REQ-029 Reset mid-frame aborts the frame immediately with no done pulse.
- After rstn rises, the block waits in IDLE for a new start.

Verification
REQ-030 Write buffer[i] = i - 288 for i = 0..575; start with state = 0 -> ovalid high for 576 consecutive cycles starting 2 cycles after start; dout = -288 .. 287; done pulses once, one cycle after the last word.
REQ-031 Write buffer[i] = i for i = 0..63; start with state = 1 -> 64 valid words, 0..63; done pulses; busy low thereafter.
REQ-032 During a state = 0 frame, pulse start, toggle state and write buffer[5] = 999 -> frame still 576 words, unchanged; a second frame still shows the original buffer[5].
REQ-033 Assert rstn low after word 100 -> ovalid, dout, busy and done go to 0 immediately with no done pulse; after release, start with state = 0 streams the full 576 words from word 0 with the original data.
REQ-034 In IDLE, in the same cycle: wr_en = 1, wr_addr = 0, wr_data = 7, start = 1 -> first streamed word is 7.
REQ-035 Write wr_addr = 600 in IDLE, then stream -> all 576 words unchanged; no X on dout.

Source files
------------

// File: rtl/fmap_streamer.sv
// Frame-buffer streamer: holds one feature map and replays it in raster order,
// one word per cycle, into a pooling stage that cannot apply backpressure.
`timescale 1ns/1ps

module fmap_streamer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 576
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     state,
    input  logic                     wr_en,
    input  logic [9:0]               wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     start,
    output logic                     ovalid,
    output logic signed [DATA_W-1:0] dout,
    output logic                     busy,
    output logic                     done
);

    localparam int ADDR_W = 10;
    // One extra bit so a counter can hold the frame length itself.
    localparam logic [ADDR_W:0] FULL_LEN  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] SMALL_LEN = 11'd64;

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, FINISH} fsm_t;

    fsm_t                     fsm;
    logic [ADDR_W:0]          frame_len;
    logic [ADDR_W:0]          rd_cnt;
    logic [ADDR_W:0]          rd_addr;
    logic                     rd_en;
    logic                     wr_ok;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] mem [DEPTH];

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        rd_addr = '0;
        if (fsm == STREAM)
            rd_addr = rd_cnt + 11'd1;
        rd_en = ((fsm == PREFETCH) || (fsm == STREAM)) && (rd_addr < frame_len);
        wr_ok = wr_en && ((fsm == IDLE) || (fsm == FINISH))
                && ({1'b0, wr_addr} < FULL_LEN);
    end

    // NOTE: the RAM has no reset branch; its contents must survive rstn, and a
    // reset loop over every entry would stop it mapping onto a block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr[ADDR_W-1:0]];
    end

    // The read runs one word ahead of dout: PREFETCH loads word 0, and each
    // STREAM cycle emits word k while reading word k+1.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm       <= IDLE;
            frame_len <= FULL_LEN;
            rd_cnt    <= '0;
            ovalid    <= 1'b0;
            dout      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        frame_len <= state ? SMALL_LEN : FULL_LEN;
                        rd_cnt    <= '0;
                        busy      <= 1'b1;
                        fsm       <= PREFETCH;
                    end
                end
                PREFETCH: fsm <= STREAM;
                STREAM: begin
                    if (rd_cnt == frame_len) begin
                        ovalid <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        fsm    <= FINISH;
                    end else begin
                        ovalid <= 1'b1;
                        dout   <= rd_data;
                        rd_cnt <= rd_cnt + 11'd1;
                    end
                end
                FINISH:  fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_streamer.sv
// Bench for fmap_streamer: a word-array model of the frame buffer predicts each
// streamed frame; table-driven frames plus directed and random sequences.
`timescale 1ns/1ps

module tb_fmap_streamer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 576;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     state_sel;
    logic                     wr_en;
    logic [9:0]               wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic                     ovalid;
    logic signed [DATA_W-1:0] dout;
    logic                     busy;
    logic                     done;

    int n_vec = 0;
    int n_err = 0;
    int model [DEPTH];

    fmap_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .state   (state_sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .ovalid  (ovalid),
        .dout    (dout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      sel;
        bit      with_start;
        int      addr;
        int      data;
        int      exp_len;
        longint  exp_word0;
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_write(input int addr, input int data);
        if (addr >= 0 && addr < DEPTH)
            model[addr] = data;
    endtask

    // Single write while idle; out-of-range addresses must leave the buffer alone.
    task automatic do_write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = addr[9:0];
        wr_data = data;
        tick();
        wr_en = 1'b0;
        model_write(addr, data);
    endtask

    // Streams one frame from IDLE (called at a negedge) and checks every cycle.
    task automatic run_frame(input bit sel, input bit disturb, input int abort_at,
                             input bit with_start, input int waddr, input int wdata,
                             output int n_valid, output longint first_word);
        int     len;
        int     exp_q [$];
        len        = sel ? 64 : DEPTH;
        n_valid    = 0;
        first_word = -99999;
        if (with_start) begin
            wr_en   = 1'b1;
            wr_addr = waddr[9:0];
            wr_data = wdata;
            model_write(waddr, wdata);
        end
        for (int i = 0; i < len; i++)
            exp_q.push_back(model[i]);
        state_sel = sel;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        state_sel = $urandom_range(0, 1);
        check("prefetch_busy", busy, 1);
        check("prefetch_ovalid", ovalid, 0);
        tick();
        check("latency_ovalid", ovalid, 0);
        for (int k = 0; k < len; k++) begin
            tick();
            if (ovalid === 1'b1) n_valid++;
            if (k == 0) first_word = dout;
            check("word_valid", ovalid, 1);
            check("word_data", dout, exp_q[k]);
            check("word_busy_done", {busy, done}, 2'b10);
            if (disturb && k == 10) begin
                start     = 1'b1;
                state_sel = ~sel;
                wr_en     = 1'b1;
                wr_addr   = 10'd5;
                wr_data   = 999;
            end
            if (disturb && k == 11) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (k == abort_at) begin
                rstn = 1'b0;
                #1;
                check("abort_outputs", {ovalid, busy, done}, 3'b000);
                check("abort_dout", dout, 0);
                for (int c = 0; c < 3; c++) begin
                    tick();
                    check("abort_no_done", {ovalid, done}, 2'b00);
                end
                rstn = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    check("abort_idle", {ovalid, busy, done}, 3'b000);
                end
                return;
            end
        end
        tick();
        check("finish_flags", {ovalid, busy, done}, 3'b001);
        check("finish_dout_hold", dout, exp_q[len-1]);
        if (disturb) begin
            // Start in FINISH must be dropped; a write there must land.
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = 10'd10;
            wr_data = -1234;
            model_write(10, -1234);
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("idle_flags", {ovalid, busy, done}, 3'b000);
        tick();
        check("idle_stays", {ovalid, busy, done}, 3'b000);
    endtask

    initial begin
        vec_t   vecs [6];
        int     nv;
        longint fw;

        vecs[0] = '{sel: 1'b0, with_start: 1'b1, addr: 0,    data: 7,    exp_len: 576, exp_word0: 7};
        vecs[1] = '{sel: 1'b1, with_start: 1'b0, addr: 600,  data: 55,   exp_len: 64,  exp_word0: 7};
        vecs[2] = '{sel: 1'b1, with_start: 1'b1, addr: 0,    data: -1,   exp_len: 64,  exp_word0: -1};
        vecs[3] = '{sel: 1'b0, with_start: 1'b0, addr: 1023, data: 9,    exp_len: 576, exp_word0: -1};
        vecs[4] = '{sel: 1'b0, with_start: 1'b1, addr: 0,    data: -288, exp_len: 576, exp_word0: -288};
        vecs[5] = '{sel: 1'b1, with_start: 1'b1, addr: 63,   data: 42,   exp_len: 64,  exp_word0: -288};

        rstn      = 1'b0;
        state_sel = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        #1;
        check("reset_flags", {ovalid, busy, done}, 3'b000);
        check("reset_dout", dout, 0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("post_reset_idle", {ovalid, busy, done}, 3'b000);

        // 8x8 frame of 0..63.
        for (int i = 0; i < 64; i++) do_write(i, i);
        run_frame(1'b1, 1'b0, -1, 1'b0, 0, 0, nv, fw);
        check("small_len", nv, 64);
        repeat (4) tick();
        check("small_busy_after", busy, 0);

        // 24x24 frame of -288..287.
        for (int i = 0; i < DEPTH; i++) do_write(i, i - 288);
        run_frame(1'b0, 1'b0, -1, 1'b0, 0, 0, nv, fw);
        check("full_len", nv, 576);
        check("full_word0", fw, -288);

        for (int v = 0; v < 6; v++) begin
            if (!vecs[v].with_start) do_write(vecs[v].addr, vecs[v].data);
            run_frame(vecs[v].sel, 1'b0, -1, vecs[v].with_start,
                      vecs[v].addr, vecs[v].data, nv, fw);
            check("tbl_len", nv, vecs[v].exp_len);
            check("tbl_word0", fw, vecs[v].exp_word0);
        end

        // Start, state toggle and a write to [5] while streaming are all dropped.
        run_frame(1'b0, 1'b1, -1, 1'b0, 0, 0, nv, fw);
        check("disturb_len", nv, 576);
        run_frame(1'b0, 1'b0, -1, 1'b0, 0, 0, nv, fw);
        check("disturb_second_len", nv, 576);

        // Reset after word 100, then a clean full frame with intact data.
        run_frame(1'b0, 1'b0, 100, 1'b0, 0, 0, nv, fw);
        run_frame(1'b0, 1'b0, -1, 1'b0, 0, 0, nv, fw);
        check("after_abort_len", nv, 576);

        for (int it = 0; it < 6; it++) begin
            int nw;
            bit sel;
            nw = $urandom_range(1, 20);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, 700), int'($urandom));
            sel = $urandom_range(0, 1);
            run_frame(sel, bit'($urandom_range(0, 1)), -1, bit'($urandom_range(0, 1)),
                      $urandom_range(0, 700), int'($urandom), nv, fw);
            check("rand_len", nv, sel ? 64 : 576);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
